// File: rtl/imem_fetch_arbiter.sv
// Instruction fetch sequencer sharing a single-port instruction memory between
// the fetch stage and a program loader. Owns the PC, the registered IF output,
// stall/redirect handling and a LOAD/RUN mode machine with bounded loader wait.
module imem_fetch_arbiter #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          LOAD_MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        running
);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  localparam logic [7:0] MAX_WAIT = 8'(LOAD_MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        load_grant;

  // Word alignment drops the loader byte-offset bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^load_addr[1:0];

  // Port ownership: loader in LOAD, or in RUN when stalled or starved too long.
  // Reset gates the grant so a write aborts the moment rst_n falls.
  always_comb begin
    load_grant = 1'b0;
    if (rst_n) begin
      if (state_q == S_LOAD) begin
        load_grant = 1'b1;
      end else if (!halt_req && load_valid && (stall || wait_cnt_q == MAX_WAIT)) begin
        load_grant = 1'b1;
      end
    end
    load_ready = load_grant;
    mem_we     = load_grant && load_valid;
    mem_addr   = load_grant ? {load_addr[31:2], 2'b00} : pc_q;
    mem_wdata  = load_data;
  end

  // Next-state for the mode machine, PC, loader wait counter and IF output.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    unique case (state_q)
      S_LOAD: begin
        wait_cnt_d = 8'd0;
        if_valid_d = 1'b0;
        // A start overlapping a loader write waits until the write stream ends.
        if (start && !load_valid) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          // The fetch in flight this cycle is dropped.
          state_d    = S_LOAD;
          if_valid_d = 1'b0;
          wait_cnt_d = 8'd0;
        end else if (load_grant) begin
          wait_cnt_d = 8'd0;
          if (redirect_valid) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
          end else if (!stall) begin
            // Forced grant steals a fetch slot: emit a bubble, PC holds.
            if_valid_d = 1'b0;
          end
        end else begin
          if (!load_valid) begin
            wait_cnt_d = 8'd0;
          end else if (wait_cnt_q != MAX_WAIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
          if (redirect_valid) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
          end else if (!stall) begin
            if_instr_d = mem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      pc_q       <= RESET_PC;
      wait_cnt_q <= 8'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign running  = (state_q == S_RUN);

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a behavioural instruction memory.
module tb_imem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        load_valid, load_ready;
  logic [31:0] load_addr, load_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        if_valid, running;
  logic [31:0] if_pc, if_instr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];

  imem_fetch_arbiter #(.RESET_PC(32'h0), .LOAD_MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ld_addr [6] = '{32'h0, 32'h4, 32'hB, 32'h100, 32'h104, 32'hFFC};
  logic [31:0] ld_data [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hC3};

  initial begin
    rst_n = 1'b0; start = 0; halt_req = 0; stall = 0; redirect_valid = 0;
    redirect_pc = 0; load_valid = 1'b1; load_addr = 0; load_data = 0;
    #3;
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    load_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Loader writes in LOAD.
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1; load_addr = ld_addr[i]; load_data = ld_data[i];
      #1;
      chk("ld_ready", 32'(load_ready), 32'd1);
      chk("ld_we", 32'(mem_we), 32'd1);
      chk("ld_addr", mem_addr, {ld_addr[i][31:2], 2'b00});
      chk("ld_wdata", mem_wdata, ld_data[i]);
      chk("ld_if_valid", 32'(if_valid), 32'd0);
      chk("ld_running", 32'(running), 32'd0);
      tick();
    end
    load_valid = 1'b0;

    // Start and fetch.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_running", 32'(running), 32'd1);
    chk("run_first_valid", 32'(if_valid), 32'd0);
    chk("run_mem_addr", mem_addr, 32'h0);
    chk("run_ready", 32'(load_ready), 32'd0);
    tick();
    chk("f0_pc", if_pc, 32'h0); chk("f0_instr", if_instr, 32'hA0); chk("f0_v", 32'(if_valid), 32'd1);
    tick();
    chk("f1_pc", if_pc, 32'h4); chk("f1_instr", if_instr, 32'hA1); chk("f1_v", 32'(if_valid), 32'd1);

    // Stall two cycles at if_pc=4.
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_pc", if_pc, 32'h4); chk("st_instr", if_instr, 32'hA1); chk("st_v", 32'(if_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("f2_pc", if_pc, 32'h8); chk("f2_instr", if_instr, 32'hA2);

    // Redirect overrides stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("rd_bubble", 32'(if_valid), 32'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    chk("rd_mem_addr", mem_addr, 32'h100);
    tick();
    chk("rd_pc", if_pc, 32'h100); chk("rd_instr", if_instr, 32'hB0); chk("rd_v", 32'(if_valid), 32'd1);
    tick();
    chk("rd_pc2", if_pc, 32'h104); chk("rd_instr2", if_instr, 32'hB1);

    // Loader starved for LOAD_MAX_WAIT fetch cycles, then forced grant.
    load_valid = 1'b1; load_addr = 32'h200; load_data = 32'h55;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("wt_ready", 32'(load_ready), 32'd0);
      chk("wt_we", 32'(mem_we), 32'd0);
      tick();
      chk("wt_pc", if_pc, 32'h108 + 32'(4 * k));
      chk("wt_v", 32'(if_valid), 32'd1);
    end
    #1;
    chk("fg_ready", 32'(load_ready), 32'd1);
    chk("fg_we", 32'(mem_we), 32'd1);
    chk("fg_addr", mem_addr, 32'h200);
    tick();
    load_valid = 1'b0;
    chk("fg_bubble", 32'(if_valid), 32'd0);
    chk("fg_mem_written", mem[32'h200 >> 2], 32'h55);
    #1;
    chk("fg_pc_hold", mem_addr, 32'h128);
    tick();
    chk("fg_resume_pc", if_pc, 32'h128); chk("fg_resume_v", 32'(if_valid), 32'd1);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wr_bubble", 32'(if_valid), 32'd0);
    chk("wr_mem_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc", if_pc, 32'hFFFF_FFFC); chk("wr_instr", if_instr, 32'hC3);
    chk("wr_next", mem_addr, 32'h0);
    tick();
    chk("wr_pc0", if_pc, 32'h0); chk("wr_instr0", if_instr, 32'hA0);

    // Halt beats a pending loader request.
    halt_req = 1'b1; load_valid = 1'b1; load_addr = 32'h300; load_data = 32'h77;
    #1;
    chk("ht_ready", 32'(load_ready), 32'd0);
    chk("ht_we", 32'(mem_we), 32'd0);
    tick();
    halt_req = 1'b0;
    chk("ht_running", 32'(running), 32'd0);
    chk("ht_if_valid", 32'(if_valid), 32'd0);
    #1;
    chk("ht_ready_next", 32'(load_ready), 32'd1);
    chk("ht_we_next", 32'(mem_we), 32'd1);

    // Start overlapping load_valid is deferred.
    start = 1'b1;
    tick();
    chk("sd_wait1", 32'(running), 32'd0);
    tick();
    chk("sd_wait2", 32'(running), 32'd0);
    load_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("sd_run", 32'(running), 32'd1);
    tick();
    chk("sd_pc", if_pc, 32'h0); chk("sd_v", 32'(if_valid), 32'd1);

    // Reset in the middle of a stall-granted loader write.
    stall = 1'b1; load_valid = 1'b1; load_addr = 32'h400; load_data = 32'h99;
    #1;
    chk("ar_we_pre", 32'(mem_we), 32'd1);
    chk("ar_ready_pre", 32'(load_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_we", 32'(mem_we), 32'd0);
    chk("ar_ready", 32'(load_ready), 32'd0);
    chk("ar_running", 32'(running), 32'd0);
    chk("ar_if_valid", 32'(if_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
